// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - hazard inputs, stage controls and counters of the Y86-64 pipeline control unit
interface pipe_ctrl_if #(parameter int CNT_W = 32);
  logic             run_en;
  logic             cnt_clr;
  logic [3:0]       D_icode;
  logic [3:0]       d_srcA;
  logic [3:0]       d_srcB;
  logic [3:0]       E_icode;
  logic [3:0]       E_dstM;
  logic             e_Cnd;
  logic [3:0]       M_icode;
  logic [2:0]       m_stat;
  logic [3:0]       W_icode;
  logic [2:0]       W_stat;
  logic             F_stall;
  logic             D_stall;
  logic             D_bubble;
  logic             E_stall;
  logic             E_bubble;
  logic             M_stall;
  logic             M_bubble;
  logic             W_stall;
  logic             set_cc;
  logic             halted;
  logic [2:0]       halt_stat;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] ret_cnt;
  logic [CNT_W-1:0] lu_cnt;
  logic [CNT_W-1:0] mp_cnt;
  logic [CNT_W-1:0] inst_cnt;

  modport master (
    output run_en, cnt_clr, D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
           M_icode, m_stat, W_icode, W_stat,
    input  F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble,
           W_stall, set_cc, halted, halt_stat, cyc_cnt, ret_cnt, lu_cnt,
           mp_cnt, inst_cnt
  );

  modport slave (
    input  run_en, cnt_clr, D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
           M_icode, m_stat, W_icode, W_stat,
    output F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble,
           W_stall, set_cc, halted, halt_stat, cyc_cnt, ret_cnt, lu_cnt,
           mp_cnt, inst_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - Y86-64 hazard detection, stage stall/bubble control, flush/run/halt FSM and perf counters
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input logic        clk,
  input logic        rst_n,
  pipe_ctrl_if.slave pc
);
  localparam logic [3:0] I_NOP = 4'd1, I_JXX = 4'd7, I_OPQ = 4'd6;
  localparam logic [3:0] I_MRMOVQ = 4'd5, I_RET = 4'd9, I_POPQ = 4'd11;
  localparam logic [2:0] S_AOK = 3'd1, S_HLT = 3'd2, S_ADR = 3'd3, S_INS = 3'd4;
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {ST_FLUSH, ST_RUN, ST_HALT} state_t;

  state_t           state_q;
  logic [FW-1:0]    flush_cnt_q;
  logic             halted_q;
  logic [2:0]       halt_stat_q;
  logic [CNT_W-1:0] cyc_q, ret_q, lu_q, mp_q, inst_q;

  logic lu, ret, mp, exc, w_bad, counting;

  assign lu  = (pc.E_icode == I_MRMOVQ || pc.E_icode == I_POPQ) && pc.E_dstM != 4'hF &&
               (pc.E_dstM == pc.d_srcA || pc.E_dstM == pc.d_srcB);
  assign ret = pc.D_icode == I_RET || pc.E_icode == I_RET || pc.M_icode == I_RET;
  assign mp  = pc.E_icode == I_JXX && !pc.e_Cnd;
  assign exc = pc.m_stat == S_ADR || pc.m_stat == S_INS || pc.m_stat == S_HLT ||
               pc.W_stat == S_ADR || pc.W_stat == S_INS || pc.W_stat == S_HLT;
  assign w_bad    = pc.W_stat != S_AOK;
  assign counting = state_q == ST_RUN && pc.run_en;

  always_comb begin
    pc.F_stall  = 1'b0;
    pc.D_stall  = 1'b0;
    pc.D_bubble = 1'b0;
    pc.E_stall  = 1'b0;
    pc.E_bubble = 1'b0;
    pc.M_stall  = 1'b0;
    pc.M_bubble = 1'b0;
    pc.W_stall  = 1'b0;
    pc.set_cc   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (pc.run_en) begin
          pc.F_stall  = lu | ret;
          pc.D_stall  = lu;
          // D_stall overrides any bubble request on the same stage
          pc.D_bubble = (mp | (ret & ~lu)) & ~lu;
          pc.E_bubble = mp | lu;
          pc.M_bubble = exc;
          pc.W_stall  = w_bad;
          pc.set_cc   = pc.E_icode == I_OPQ && !exc;
        end else begin
          pc.F_stall = 1'b1;
          pc.D_stall = 1'b1;
          pc.E_stall = 1'b1;
          pc.M_stall = 1'b1;
          pc.W_stall = 1'b1;
        end
      end
      ST_HALT: begin
        pc.F_stall = 1'b1;
        pc.D_stall = 1'b1;
        pc.E_stall = 1'b1;
        pc.M_stall = 1'b1;
        pc.W_stall = 1'b1;
      end
      default: begin
        pc.F_stall  = 1'b1;
        pc.D_bubble = 1'b1;
        pc.E_bubble = 1'b1;
        pc.M_bubble = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FLUSH;
      flush_cnt_q <= '0;
      halted_q    <= 1'b0;
      halt_stat_q <= S_AOK;
    end else begin
      case (state_q)
        ST_FLUSH: begin
          flush_cnt_q <= flush_cnt_q + 1'b1;
          if (flush_cnt_q == FLUSH_LAST) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (w_bad) begin
            state_q     <= ST_HALT;
            halted_q    <= 1'b1;
            halt_stat_q <= pc.W_stat;
          end
        end
        default: state_q <= ST_HALT;
      endcase
    end
  end

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic en);
    return (en && v != '1) ? v + 1'b1 : v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q  <= '0;
      ret_q  <= '0;
      lu_q   <= '0;
      mp_q   <= '0;
      inst_q <= '0;
    end else if (pc.cnt_clr) begin
      cyc_q  <= '0;
      ret_q  <= '0;
      lu_q   <= '0;
      mp_q   <= '0;
      inst_q <= '0;
    end else begin
      cyc_q  <= bump(cyc_q, counting);
      ret_q  <= bump(ret_q, counting && ret && !lu);
      lu_q   <= bump(lu_q, counting && lu);
      mp_q   <= bump(mp_q, counting && mp);
      inst_q <= bump(inst_q, counting && pc.W_icode != I_NOP && pc.W_stat == S_AOK);
    end
  end

  assign pc.halted    = halted_q;
  assign pc.halt_stat = halt_stat_q;
  assign pc.cyc_cnt   = cyc_q;
  assign pc.ret_cnt   = ret_q;
  assign pc.lu_cnt    = lu_q;
  assign pc.mp_cnt    = mp_q;
  assign pc.inst_cnt  = inst_q;
endmodule
